semaforo_monitor: RTL
=====================

Name: semaforo_monitor

Overview:
- Passive checker at the receiving end of the traffic-light interface. It observes the A/B light buses and the pedestrian button `bt` that drive and feed the `semaforo` controller.
- Flags illegal encodings, conflicting greens, illegal colour sequences and wrong dwell times, and keeps error status and counts.
- Instantiated next to `semaforo` in testbenches and in the top level for on-board self-check. It drives no light signals.

Parameters:
- VERDE, 8'd1, required minimum cycles of A green; the button may extend green.
- AMARELO, 8'd3, exact cycles of A yellow.
- VERMELHO, 8'd2, required minimum cycles of A red.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- bt  in  1  pedestrian button, as seen by the controller.
- A  in  3  light A: [0]=green, [1]=yellow, [2]=red.
- B  in  3  light B, same encoding.
- err_valid  out  1  one-cycle pulse, set on the edge that sampled a violation.
- err_code  out  3  code of the highest-priority violation; holds its value until the next error.
- err_sticky  out  1  set on the first error, cleared only by rst.
- err_count  out  8  number of cycles with an error; saturates at 255.
- press_count  out  8  rising edges of bt; saturates at 255.
- dwell_a  out  8  cycles A has been in its current colour; saturates at 255.

Behaviour:
- Reset: on any rising edge with rst=1, every output, internal register and previous-sample register goes to 0, and the trackers enter the NOPREV state.
- Sampling: inputs are sampled at edge N. Flags from that sample are registered at edge N and visible during cycle N+1. Latency is 1 cycle.
- Error codes, with priority lowest first:
  - 1 ENC_A: A is not one-hot.
  - 2 ENC_B: B is not one-hot.
  - 3 CONFLICT: A and B both non-red.
  - 4 TRANS_A: illegal A transition.
  - 5 TRANS_B: illegal B transition.
  - 6 DWELL_A: wrong A dwell.
- Only the lowest active code is reported. err_count increments by 1 per error cycle, not per code.
- Tracker FSM, one per light, states NOPREV, GREEN, YELLOW, RED:
  - NOPREV is entered on reset. It takes the colour of the first valid sample and performs no transition or dwell check on that sample.
  - Legal changes: GREEN->YELLOW, YELLOW->RED, RED->GREEN. An unchanged colour is always legal.
  - Any other change raises TRANS. The tracker still moves to the observed colour so that checking resynchronises.
- Invalid-encoding sample:
  - Raises ENC.
  - The tracker holds its state and its dwell counter.
  - The next valid sample is not checked against the held state; the tracker re-enters through NOPREV.
- Dwell counter:
  - Value 1 on the first cycle of a colour; +1 per cycle while the colour is unchanged; saturates at 255.
  - Checked on the exit edge, i.e. the edge that samples a new colour.
  - GREEN exit requires dwell >= VERDE. YELLOW exit requires dwell == AMARELO. RED exit requires dwell >= VERMELHO.
  - A YELLOW with no exit yet fails as soon as dwell reaches AMARELO+1, flagged once at that edge.
  - The dwell check is enabled for A only; B's tracker has it disabled.
- Simultaneous events: a transition error and a dwell error on the same edge report TRANS, and DWELL is suppressed for that exit.
- press_count increments when bt=1 and the previous sample was 0. A held button counts once.
- Reset mid-operation: counts are discarded and checking restarts through NOPREV, with no false TRANS or DWELL on the first post-reset sample.
- Combined outputs: err_sticky = OR of past err_valid. err_code resets to 0, meaning no error yet.

Decomposition:
- semaforo_pkg:
  - colour bit positions (GREEN_BIT=0, YELLOW_BIT=1, RED_BIT=2);
  - tracker state encoding (NOPREV, GREEN, YELLOW, RED);
  - error codes ERR_NONE..ERR_DWELL_A;
  - the 8-bit count width.
- Sub-module semaforo_light_tracker:
  - parameters DWELL_EN, MIN_G, EXACT_Y, MIN_R;
  - outputs enc_err, trans_err, dwell_err, nonred, dwell;
  - instantiated twice, for A and B.
- The top module contains the priority encoder, conflict check, counters and button edge detector.

Test Plan:
- Legal run: rst for 1 cycle, then A = G x1, Y x3, R x2, G..., with B mirrored (R while A is non-red, cycling G/Y while A is red) for 40 cycles -> err_sticky=0, err_count=0, dwell_a=1 on each A colour change.
- Short yellow: A = G x1, Y x2, R -> err_valid pulses for 1 cycle in the cycle after R is sampled; err_code=6, err_count=1.
- Conflict: A=3'b001 and B=3'b001 for 2 cycles -> err_code=3, err_count=2, err_sticky=1.
- Illegal transition plus bad encoding: A G->R gives err_code=4; then A=3'b011 gives err_code=1. The next valid A produces no TRANS.
- Button: bt high for 3 cycles, low for 2, high for 1 -> press_count=2. An A green lasting 5 cycles with VERDE=1 gives no error.
- Reset mid-operation: assert rst during A yellow with dwell_a=2, release, then A=R -> all outputs 0 after reset and no error on the first post-reset samples.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light monitor: colour bit positions,
// tracker states, error codes and saturating count helpers.
package semaforo_pkg;

    localparam int unsigned GREEN_BIT  = 0;
    localparam int unsigned YELLOW_BIT = 1;
    localparam int unsigned RED_BIT    = 2;
    localparam int unsigned CNT_W      = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        NOPREV = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } trk_state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ENC_A    = 3'd1,
        ERR_ENC_B    = 3'd2,
        ERR_CONFLICT = 3'd3,
        ERR_TRANS_A  = 3'd4,
        ERR_TRANS_B  = 3'd5,
        ERR_DWELL_A  = 3'd6
    } err_code_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    // NOPREV doubles as "not a one-hot colour"
    function automatic trk_state_t decode_light(input logic [2:0] l);
        trk_state_t s;
        s = NOPREV;
        if (l == (3'b001 << GREEN_BIT))  s = GREEN;
        if (l == (3'b001 << YELLOW_BIT)) s = YELLOW;
        if (l == (3'b001 << RED_BIT))    s = RED;
        return s;
    endfunction

    function automatic trk_state_t successor(input trk_state_t s);
        trk_state_t n;
        case (s)
            GREEN:   n = YELLOW;
            YELLOW:  n = RED;
            RED:     n = GREEN;
            default: n = NOPREV;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// Light buses and pedestrian button shared by the controller and its monitor.
interface semaforo_monitor_if;
    logic       bt;
    logic [2:0] A;
    logic [2:0] B;

    modport master (output bt, A, B);
    modport slave  (input  bt, A, B);
endinterface

// File: rtl/semaforo_light_tracker.sv
// Per-light colour tracker: encoding, transition and dwell-time checks.
module semaforo_light_tracker
    import semaforo_pkg::*;
#(
    parameter bit   DWELL_EN = 1'b1,
    parameter cnt_t MIN_G    = 8'd1,
    parameter cnt_t EXACT_Y  = 8'd3,
    parameter cnt_t MIN_R    = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output logic       enc_err,
    output logic       trans_err,
    output logic       dwell_err,
    output logic       nonred,
    output cnt_t       dwell
);

    trk_state_t state, state_nx, seen;
    cnt_t       dwell_nx;
    logic       resync, resync_nx;

    // state, dwell counter and resync flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= NOPREV;
            dwell  <= '0;
            resync <= 1'b0;
        end else begin
            state  <= state_nx;
            dwell  <= dwell_nx;
            resync <= resync_nx;
        end
    end

    // next state, dwell update and violation flags for the current sample
    always_comb begin
        state_nx  = state;
        dwell_nx  = dwell;
        resync_nx = resync;
        enc_err   = 1'b0;
        trans_err = 1'b0;
        dwell_err = 1'b0;
        seen      = decode_light(light);
        nonred    = (seen != NOPREV) && (seen != RED);

        if (seen == NOPREV) begin
            // invalid sample: hold state/dwell, next valid sample re-enters unchecked
            enc_err   = 1'b1;
            resync_nx = 1'b1;
        end else if (state == NOPREV || resync) begin
            state_nx  = seen;
            dwell_nx  = cnt_t'(1);
            resync_nx = 1'b0;
        end else if (seen == state) begin
            dwell_nx = sat_inc(dwell);
            if (DWELL_EN && state == YELLOW && dwell == EXACT_Y)
                dwell_err = 1'b1;
        end else begin
            state_nx = seen;
            dwell_nx = cnt_t'(1);
            if (seen != successor(state)) begin
                trans_err = 1'b1;
            end else if (DWELL_EN) begin
                case (state)
                    GREEN:   dwell_err = (dwell < MIN_G);
                    // an overstayed yellow was already reported when it crossed EXACT_Y
                    YELLOW:  dwell_err = (dwell < EXACT_Y);
                    RED:     dwell_err = (dwell < MIN_R);
                    default: dwell_err = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker for the traffic-light controller outputs and button input.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter cnt_t VERDE    = 8'd1,
    parameter cnt_t AMARELO  = 8'd3,
    parameter cnt_t VERMELHO = 8'd2
) (
    input  logic                clk,
    input  logic                rst,
    semaforo_monitor_if.slave   bus,
    output logic                err_valid,
    output logic [2:0]          err_code,
    output logic                err_sticky,
    output cnt_t                err_count,
    output cnt_t                press_count,
    output cnt_t                dwell_a
);

    logic      enc_a, trans_a, dwell_err_a, nonred_a;
    logic      enc_b, trans_b, nonred_b;
    cnt_t      dwell_b;
    logic      dwell_err_b;
    logic [CNT_W:0] b_unused;
    logic      bt_prev;
    err_code_t code_nx, code_q;

    semaforo_light_tracker #(
        .DWELL_EN (1'b1),
        .MIN_G    (VERDE),
        .EXACT_Y  (AMARELO),
        .MIN_R    (VERMELHO)
    ) u_trk_a (
        .clk       (clk),
        .rst       (rst),
        .light     (bus.A),
        .enc_err   (enc_a),
        .trans_err (trans_a),
        .dwell_err (dwell_err_a),
        .nonred    (nonred_a),
        .dwell     (dwell_a)
    );

    semaforo_light_tracker #(
        .DWELL_EN (1'b0),
        .MIN_G    (VERDE),
        .EXACT_Y  (AMARELO),
        .MIN_R    (VERMELHO)
    ) u_trk_b (
        .clk       (clk),
        .rst       (rst),
        .light     (bus.B),
        .enc_err   (enc_b),
        .trans_err (trans_b),
        .dwell_err (dwell_err_b),
        .nonred    (nonred_b),
        .dwell     (dwell_b)
    );

    // B has no dwell rule; its dwell outputs are intentionally left unused
    assign b_unused = {dwell_b, dwell_err_b};

    // priority encoder: lowest code wins
    always_comb begin
        code_nx = ERR_NONE;
        if (enc_a)                     code_nx = ERR_ENC_A;
        else if (enc_b)                code_nx = ERR_ENC_B;
        else if (nonred_a && nonred_b) code_nx = ERR_CONFLICT;
        else if (trans_a)              code_nx = ERR_TRANS_A;
        else if (trans_b)              code_nx = ERR_TRANS_B;
        else if (dwell_err_a)          code_nx = ERR_DWELL_A;
    end

    // error status, counters and button edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid   <= 1'b0;
            code_q      <= ERR_NONE;
            err_sticky  <= 1'b0;
            err_count   <= '0;
            press_count <= '0;
            bt_prev     <= 1'b0;
        end else begin
            err_valid <= (code_nx != ERR_NONE);
            if (code_nx != ERR_NONE) begin
                code_q     <= code_nx;
                err_sticky <= 1'b1;
                err_count  <= sat_inc(err_count);
            end
            bt_prev <= bus.bt;
            if (bus.bt && !bt_prev)
                press_count <= sat_inc(press_count);
        end
    end

    assign err_code = code_q;

endmodule
